tx_quad_rst_ctrl: RTL and testbench
===================================

# tx_quad_rst_ctrl

Parametrised TX reset sequencer for one SERDES quad, successor to the fixed 4-channel TX reset state machine. Drives quad and per-lane TX PCS resets from PLL loss-of-lock, adds a lane-enable mask, debounced lock-loss detection, bounded retry with a sticky failure state and a software reset request. Sits between the quad PCS hard macro and the per-lane PCS wrappers, clocked from the quad's refclkdiv2.

## Interface
- NUM_CH, 4: lanes in the quad (1..4).
- T1_W, 3: quad-reset timer width; dwell set by bit T1_W-1.
- T2_W, 19: PLL-lock timer width; dwell set by bit T2_W-1.
- LOL_DEB, 4: consecutive high cycles of synchronised LOL needed in NORMAL before re-reset (1..15).
- MAX_RETRY, 7: consecutive failed lock checks before FAIL (1..15).

- refclkdiv2  in  1  clock.
- rst_n  in  1  Reset: rst_n, asynchronous, active-low; clock refclkdiv2.
- tx_pll_lol_qd_s  in  1  PLL loss-of-lock, asynchronous level.
- ch_en  in  NUM_CH  lane enable mask, quasi-static.
- sw_rst_req  in  1  single-cycle restart request.
- rst_qd_c  out  1  quad reset, registered.
- tx_pcs_rst_ch_c  out  NUM_CH  per-lane TX PCS reset, registered.
- tx_ready  out  1  high only while in NORMAL, registered.
- lock_fail  out  1  high only while in FAIL, registered.
- retry_cnt  out  4  consecutive failed lock checks, saturating.

## Operation
- LOL passes a 2-flop synchroniser, both flops reset to 1.
- States: QUAD_RESET, WAIT_T1, CHECK_PLOL, WAIT_T2, NORMAL, FAIL; undefined encodings go to QUAD_RESET.
- QUAD_RESET: rst_qd=1, lanes all 1, timer1 cleared; -> WAIT_T1.
- WAIT_T1: rst_qd=1, lanes all 1; -> CHECK_PLOL when timer1 bit T1_W-1 is 1.
- CHECK_PLOL: rst_qd=0, lanes all 1, timer2 cleared; -> WAIT_T2.
- WAIT_T2: rst_qd=0, lanes all 1; at timer2 terminal bit: LOL=0 -> NORMAL, retry_cnt cleared; LOL=1 -> retry_cnt+1, then FAIL if new value = MAX_RETRY, else QUAD_RESET.
- NORMAL: rst_qd=0, tx_pcs_rst_ch_c[i] = ~ch_en[i]; debounce counter increments while LOL=1, clears when LOL=0; reaching LOL_DEB -> QUAD_RESET.
- FAIL: rst_qd=1, lanes all 1; exits only on sw_rst_req or rst_n.
- sw_rst_req=1 in any state: next state QUAD_RESET, retry_cnt and debounce cleared; takes priority over all other transitions.
- Reset values: rst_qd_c=1, tx_pcs_rst_ch_c=all 1, tx_ready=0, lock_fail=0, retry_cnt=0, state QUAD_RESET.

## Timing
- Outputs are registered from next-state decode; they follow the state register with zero extra lag, i.e. they change on the same edge as the state.
- Timers count up each cycle inside their WAIT state. WAIT_T1 lasts 2^(T1_W-1)+1 cycles (5 at default). WAIT_T2 lasts 2^(T2_W-1)+1 cycles.
- LOL reaches the FSM 2 cycles after the input changes. In NORMAL, a steady LOL assertion causes exit after 2+LOL_DEB cycles.
- ch_en changes in NORMAL appear on tx_pcs_rst_ch_c on the next edge.
- retry_cnt saturates at 15. It updates on the WAIT_T2 exit edge.

## Configuration
- TX_RST_SIM_SHORT_EN defined: timer2 terminal is bit 4 (17-cycle WAIT_T2) for simulation.
- Undefined: timer2 terminal is bit T2_W-1.

## Structure
- Package tx_rst_pkg: state enum and default parameter constants.
- One sub-module, tx_rst_timer: clearable up-counter with a terminal-bit output, instantiated twice.

## Test plan
- Reset release, LOL=0, ch_en=4'b1011, SIM_SHORT -> rst_qd_c falls after 6 cycles; NORMAL after WAIT_T2; tx_pcs_rst_ch_c=4'b0100, tx_ready=1.
- LOL held 1, MAX_RETRY=3 -> retry_cnt goes 1, 2, 3, then lock_fail=1 and rst_qd_c=1 held; sw_rst_req -> QUAD_RESET, retry_cnt=0.
- NORMAL, LOL glitch of 3 cycles with LOL_DEB=4 -> no reset. A 4-cycle glitch -> rst_qd_c=1 six cycles after LOL rises.
- sw_rst_req mid-WAIT_T2 -> QUAD_RESET next cycle; timer2 restarts from 0 on the next CHECK_PLOL.
- rst_n asserted in NORMAL -> all outputs return to reset values immediately, without a clock edge.
- Toggle ch_en[2] in NORMAL -> tx_pcs_rst_ch_c[2] follows ~ch_en[2] one cycle later; other lanes unaffected.

Source files
------------

// File: rtl/tx_rst_pkg.sv
// Shared types and default constants for the TX quad reset sequencer.
package tx_rst_pkg;

  typedef enum logic [2:0] {
    ST_QUAD_RESET = 3'd0,
    ST_WAIT_T1    = 3'd1,
    ST_CHECK_PLOL = 3'd2,
    ST_WAIT_T2    = 3'd3,
    ST_NORMAL     = 3'd4,
    ST_FAIL       = 3'd5
  } tx_rst_state_e;

  localparam int DEF_NUM_CH    = 4;
  localparam int DEF_T1_W      = 3;
  localparam int DEF_T2_W      = 19;
  localparam int DEF_LOL_DEB   = 4;
  localparam int DEF_MAX_RETRY = 7;

  // Retry counter increment that holds at 15 instead of wrapping.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/tx_rst_timer.sv
// Clearable up-counter; o_term is one selected bit of the count, so a dwell
// of 2^TERM_BIT cycles is measured from the last clear.
module tx_rst_timer #(
  parameter int W        = 3,
  parameter int TERM_BIT = W - 1
) (
  input  logic refclkdiv2,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term
);

  logic [W-1:0] r_cnt;

  // Clear has priority over counting.
  always_ff @(posedge refclkdiv2 or negedge rst_n) begin
    if (!rst_n)     r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + W'(1);
  end

  assign o_term = r_cnt[TERM_BIT];

endmodule

// File: rtl/tx_quad_rst_ctrl.sv
// TX reset sequencer for one SERDES quad: quad reset, PLL lock wait with
// bounded retry, debounced lock-loss re-reset, per-lane enable mask.
// Build option: TX_RST_SIM_SHORT_EN shortens the PLL-lock wait to 17 cycles.
//
// state         | meaning
// QUAD_RESET    | clear timer1, quad and lanes held in reset
// WAIT_T1       | quad reset dwell
// CHECK_PLOL    | quad released, clear timer2
// WAIT_T2       | PLL lock dwell, LOL sampled at terminal
// NORMAL        | lanes released per ch_en, LOL debounced
// FAIL          | retries exhausted, held until sw_rst_req
module tx_quad_rst_ctrl
  import tx_rst_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int T1_W      = DEF_T1_W,
  parameter int T2_W      = DEF_T2_W,
  parameter int LOL_DEB   = DEF_LOL_DEB,
  parameter int MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic              refclkdiv2,
  input  logic              rst_n,
  input  logic              tx_pll_lol_qd_s,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sw_rst_req,
  output logic              rst_qd_c,
  output logic [NUM_CH-1:0] tx_pcs_rst_ch_c,
  output logic              tx_ready,
  output logic              lock_fail,
  output logic [3:0]        retry_cnt
);

`ifdef TX_RST_SIM_SHORT_EN
  localparam int LP_T2_TERM = 4;
`else
  localparam int LP_T2_TERM = T2_W - 1;
`endif
  localparam logic [3:0] LP_LOL_DEB   = 4'(LOL_DEB);
  localparam logic [3:0] LP_MAX_RETRY = 4'(MAX_RETRY);

  logic              r_lol_meta;
  logic              r_lol_s;
  tx_rst_state_e     r_state;
  tx_rst_state_e     w_state_nxt;
  logic [3:0]        r_deb_cnt;
  logic [3:0]        w_deb_nxt;
  logic [3:0]        w_deb_inc;
  logic [3:0]        r_retry_cnt;
  logic [3:0]        w_retry_nxt;
  logic [3:0]        w_retry_inc;
  logic              w_t1_term;
  logic              w_t2_term;
  logic              r_rst_qd;
  logic [NUM_CH-1:0] r_tx_pcs_rst;
  logic              r_tx_ready;
  logic              r_lock_fail;
  logic              w_rst_qd_nxt;
  logic [NUM_CH-1:0] w_tx_pcs_rst_nxt;
  logic              w_tx_ready_nxt;
  logic              w_lock_fail_nxt;

  tx_rst_timer #(.W(T1_W), .TERM_BIT(T1_W - 1)) u_timer1 (
    .refclkdiv2 (refclkdiv2),
    .rst_n      (rst_n),
    .i_clr      (r_state == ST_QUAD_RESET),
    .i_en       (r_state == ST_WAIT_T1),
    .o_term     (w_t1_term)
  );

  tx_rst_timer #(.W(T2_W), .TERM_BIT(LP_T2_TERM)) u_timer2 (
    .refclkdiv2 (refclkdiv2),
    .rst_n      (rst_n),
    .i_clr      (r_state == ST_CHECK_PLOL),
    .i_en       (r_state == ST_WAIT_T2),
    .o_term     (w_t2_term)
  );

  // LOL synchroniser; reset to 1 so lock is assumed lost until proven otherwise.
  always_ff @(posedge refclkdiv2 or negedge rst_n) begin
    if (!rst_n) begin
      r_lol_meta <= 1'b1;
      r_lol_s    <= 1'b1;
    end else begin
      r_lol_meta <= tx_pll_lol_qd_s;
      r_lol_s    <= r_lol_meta;
    end
  end

  // Next-state, counter and output decode; sw_rst_req overrides everything.
  always_comb begin
    w_state_nxt      = r_state;
    w_retry_nxt      = r_retry_cnt;
    w_deb_nxt        = '0;
    w_retry_inc      = sat_inc4(r_retry_cnt);
    w_deb_inc        = r_deb_cnt + 4'd1;
    w_rst_qd_nxt     = 1'b1;
    w_tx_pcs_rst_nxt = '1;
    w_tx_ready_nxt   = 1'b0;
    w_lock_fail_nxt  = 1'b0;

    if (sw_rst_req) begin
      w_state_nxt = ST_QUAD_RESET;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        ST_QUAD_RESET: w_state_nxt = ST_WAIT_T1;
        ST_WAIT_T1:    if (w_t1_term) w_state_nxt = ST_CHECK_PLOL;
        ST_CHECK_PLOL: w_state_nxt = ST_WAIT_T2;
        ST_WAIT_T2: begin
          if (w_t2_term) begin
            if (!r_lol_s) begin
              w_state_nxt = ST_NORMAL;
              w_retry_nxt = '0;
            end else begin
              w_retry_nxt = w_retry_inc;
              w_state_nxt = (w_retry_inc == LP_MAX_RETRY) ? ST_FAIL : ST_QUAD_RESET;
            end
          end
        end
        ST_NORMAL: begin
          if (r_lol_s) begin
            if (w_deb_inc >= LP_LOL_DEB) w_state_nxt = ST_QUAD_RESET;
            else                         w_deb_nxt   = w_deb_inc;
          end
        end
        ST_FAIL:       w_state_nxt = ST_FAIL;
        default:       w_state_nxt = ST_QUAD_RESET;
      endcase
    end

    case (w_state_nxt)
      ST_CHECK_PLOL, ST_WAIT_T2: w_rst_qd_nxt = 1'b0;
      ST_NORMAL: begin
        w_rst_qd_nxt     = 1'b0;
        w_tx_pcs_rst_nxt = ~ch_en;
        w_tx_ready_nxt   = 1'b1;
      end
      ST_FAIL:  w_lock_fail_nxt = 1'b1;
      default:  w_rst_qd_nxt    = 1'b1;
    endcase
  end

  // State, counters and outputs all update on the same edge.
  always_ff @(posedge refclkdiv2 or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_QUAD_RESET;
      r_deb_cnt    <= '0;
      r_retry_cnt  <= '0;
      r_rst_qd     <= 1'b1;
      r_tx_pcs_rst <= '1;
      r_tx_ready   <= 1'b0;
      r_lock_fail  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_deb_cnt    <= w_deb_nxt;
      r_retry_cnt  <= w_retry_nxt;
      r_rst_qd     <= w_rst_qd_nxt;
      r_tx_pcs_rst <= w_tx_pcs_rst_nxt;
      r_tx_ready   <= w_tx_ready_nxt;
      r_lock_fail  <= w_lock_fail_nxt;
    end
  end

  assign rst_qd_c        = r_rst_qd;
  assign tx_pcs_rst_ch_c = r_tx_pcs_rst;
  assign tx_ready        = r_tx_ready;
  assign lock_fail       = r_lock_fail;
  assign retry_cnt       = r_retry_cnt;

endmodule

// File: tb/tb_tx_quad_rst_ctrl.sv
// Directed bench for tx_quad_rst_ctrl. T2_W=5 gives a 17-cycle WAIT_T2 with
// or without TX_RST_SIM_SHORT_EN; MAX_RETRY=3, LOL_DEB=4.
module tb_tx_quad_rst_ctrl;

  logic       refclkdiv2;
  logic       rst_n;
  logic       tx_pll_lol_qd_s;
  logic [3:0] ch_en;
  logic       sw_rst_req;
  logic       rst_qd_c;
  logic [3:0] tx_pcs_rst_ch_c;
  logic       tx_ready;
  logic       lock_fail;
  logic [3:0] retry_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  tx_quad_rst_ctrl #(
    .NUM_CH(4), .T1_W(3), .T2_W(5), .LOL_DEB(4), .MAX_RETRY(3)
  ) dut (
    .refclkdiv2      (refclkdiv2),
    .rst_n           (rst_n),
    .tx_pll_lol_qd_s (tx_pll_lol_qd_s),
    .ch_en           (ch_en),
    .sw_rst_req      (sw_rst_req),
    .rst_qd_c        (rst_qd_c),
    .tx_pcs_rst_ch_c (tx_pcs_rst_ch_c),
    .tx_ready        (tx_ready),
    .lock_fail       (lock_fail),
    .retry_cnt       (retry_cnt)
  );

  initial refclkdiv2 = 1'b0;
  always #5 refclkdiv2 = ~refclkdiv2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Advance n rising edges, then step 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge refclkdiv2);
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    tx_pll_lol_qd_s = 1'b0;
    ch_en           = 4'b1011;
    sw_rst_req      = 1'b0;
    tick(3);
    chk("rst_qd_in_reset", rst_qd_c, 1);
    chk("lanes_in_reset", tx_pcs_rst_ch_c, 4'hF);
    chk("ready_in_reset", tx_ready, 0);
    chk("fail_in_reset", lock_fail, 0);
    chk("retry_in_reset", retry_cnt, 0);

    // Release: QUAD_RESET 1 + WAIT_T1 5 -> rst_qd falls on edge 6.
    rst_n = 1'b1;
    tick(5);
    chk("rst_qd_edge5", rst_qd_c, 1);
    tick(1);
    chk("rst_qd_edge6", rst_qd_c, 0);
    chk("lanes_check_plol", tx_pcs_rst_ch_c, 4'hF);
    // CHECK_PLOL 1 + WAIT_T2 17 -> NORMAL on edge 24.
    tick(17);
    chk("ready_edge23", tx_ready, 0);
    tick(1);
    chk("ready_edge24", tx_ready, 1);
    chk("lanes_normal", tx_pcs_rst_ch_c, 4'b0100);
    chk("retry_normal", retry_cnt, 0);

    // 3-cycle LOL glitch is absorbed.
    tx_pll_lol_qd_s = 1'b1;
    tick(3);
    tx_pll_lol_qd_s = 1'b0;
    tick(5);
    chk("glitch3_ready", tx_ready, 1);
    chk("glitch3_rst_qd", rst_qd_c, 0);

    // 4-cycle glitch forces re-reset 6 edges after LOL rises.
    tx_pll_lol_qd_s = 1'b1;
    tick(4);
    tx_pll_lol_qd_s = 1'b0;
    tick(1);
    chk("glitch4_edge5_rst_qd", rst_qd_c, 0);
    tick(1);
    chk("glitch4_edge6_rst_qd", rst_qd_c, 1);
    chk("glitch4_edge6_ready", tx_ready, 0);
    chk("glitch4_edge6_lanes", tx_pcs_rst_ch_c, 4'hF);
    tick(24);
    chk("resequence_ready", tx_ready, 1);

    // ch_en[2] toggle follows one edge later, other lanes untouched.
    ch_en = 4'b1111;
    chk("chen_no_comb_path", tx_pcs_rst_ch_c, 4'b0100);
    tick(1);
    chk("chen_set2", tx_pcs_rst_ch_c, 4'b0000);
    ch_en = 4'b1011;
    tick(1);
    chk("chen_clr2", tx_pcs_rst_ch_c, 4'b0100);

    // sw_rst_req mid WAIT_T2; timer2 must restart from zero.
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    chk("swrst_normal_rst_qd", rst_qd_c, 1);
    chk("swrst_normal_ready", tx_ready, 0);
    tick(6);
    chk("swrst_check_plol", rst_qd_c, 0);
    tick(5);
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    chk("swrst_wait_t2_rst_qd", rst_qd_c, 1);
    tick(23);
    chk("swrst_t2_restart_early", tx_ready, 0);
    tick(1);
    chk("swrst_t2_restart_ready", tx_ready, 1);

    // LOL held: debounce exit, then three failed checks -> FAIL.
    tx_pll_lol_qd_s = 1'b1;
    tick(6);
    chk("lol_hold_rst_qd", rst_qd_c, 1);
    tick(23);
    chk("retry_before_1", retry_cnt, 0);
    chk("rst_qd_before_1", rst_qd_c, 0);
    tick(1);
    chk("retry_1", retry_cnt, 1);
    chk("rst_qd_retry_1", rst_qd_c, 1);
    chk("fail_retry_1", lock_fail, 0);
    tick(24);
    chk("retry_2", retry_cnt, 2);
    chk("fail_retry_2", lock_fail, 0);
    tick(24);
    chk("retry_3", retry_cnt, 3);
    chk("fail_set", lock_fail, 1);
    chk("fail_rst_qd", rst_qd_c, 1);
    tick(20);
    chk("fail_sticky", lock_fail, 1);
    chk("fail_sticky_rst_qd", rst_qd_c, 1);
    chk("fail_lanes", tx_pcs_rst_ch_c, 4'hF);

    tx_pll_lol_qd_s = 1'b0;
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    chk("swrst_fail_clear", lock_fail, 0);
    chk("swrst_retry_clear", retry_cnt, 0);
    chk("swrst_fail_rst_qd", rst_qd_c, 1);
    tick(24);
    chk("recover_ready", tx_ready, 1);
    chk("recover_lanes", tx_pcs_rst_ch_c, 4'b0100);

    // Asynchronous reset in NORMAL, observed before any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_qd", rst_qd_c, 1);
    chk("async_lanes", tx_pcs_rst_ch_c, 4'hF);
    chk("async_ready", tx_ready, 0);
    chk("async_fail", lock_fail, 0);
    chk("async_retry", retry_cnt, 0);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
